mem_port_arbiter: RTL and testbench

- Shares the single port of the unified byte-addressable RAM between the instruction-fetch requester (I) and the load/store requester (D).
- Latches the winning request and drives the RAM address, write data, write enable and write-size select for one cycle.
- Returns registered read data with a one-cycle ready pulse.
- Blocks misaligned stores and flags misaligned loads and stores. Sits between the pipeline's IF/MEM stages and the RAM.

---
 rtl/mem_port_arbiter_if.sv | 31 +++
 rtl/mem_port_arbiter.sv | 98 +++++++++
 tb/tb_mem_port_arbiter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester and RAM-side signals of the shared memory port
interface mem_port_arbiter_if #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32
);
  logic                     i_req;
  logic [ADDRESS_WIDTH-1:0] i_addr;
  logic                     i_ready;
  logic [DATA_WIDTH-1:0]    i_rdata;
  logic                     d_req;
  logic                     d_we;
  logic [1:0]               d_sel;
  logic [ADDRESS_WIDTH-1:0] d_addr;
  logic [DATA_WIDTH-1:0]    d_wdata;
  logic                     d_ready;
  logic [DATA_WIDTH-1:0]    d_rdata;
  logic                     d_err;
  logic [ADDRESS_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]    mem_wdata;
  logic                     mem_wen;
  logic [1:0]               mem_sel;
  logic [DATA_WIDTH-1:0]    mem_rdata;
  modport slave (
    input  i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
    output i_ready, i_rdata, d_ready, d_rdata, d_err, mem_addr, mem_wdata, mem_wen, mem_sel
  );
  modport master (
    output i_req, i_addr, d_req, d_we, d_sel, d_addr, d_wdata, mem_rdata,
    input  i_ready, i_rdata, d_ready, d_rdata, d_err, mem_addr, mem_wdata, mem_wen, mem_sel
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one RAM port between fetch (I) and load/store (D), D-priority with starvation guard
module mem_port_arbiter #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int STARVE_LIMIT  = 4
) (
  input logic CLK,
  input logic RST,
  mem_port_arbiter_if.slave bus
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] LIM = SW'(STARVE_LIMIT);
  typedef enum logic [1:0] {IDLE, ACC_I, ACC_D, DONE} state_t;
  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]    wdata_q, wdata_d;
  logic                     we_q, we_d;
  logic                     mis_q, mis_d;
  logic [1:0]               sel_q, sel_d;
  logic [SW-1:0]            starve_q, starve_d;
  logic                     i_ready_q, i_ready_d;
  logic                     d_ready_q, d_ready_d;
  logic                     d_err_q, d_err_d;
  logic [DATA_WIDTH-1:0]    i_rdata_q, i_rdata_d;
  logic [DATA_WIDTH-1:0]    d_rdata_q, d_rdata_d;
  logic                     i_win;
  logic                     grant;
  always_comb begin
    i_win     = bus.i_req & (~bus.d_req | (starve_q == LIM));
    grant     = (state_q == IDLE) & (bus.i_req | bus.d_req);
    state_d   = state_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    sel_d     = sel_q;
    mis_d     = mis_q;
    starve_d  = starve_q;
    case (state_q)
      IDLE:    state_d = grant ? (i_win ? ACC_I : ACC_D) : IDLE;
      ACC_I:   state_d = DONE;
      ACC_D:   state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (grant) begin
      addr_d   = i_win ? bus.i_addr : bus.d_addr;
      wdata_d  = i_win ? '0 : bus.d_wdata;
      we_d     = ~i_win & bus.d_we;
      sel_d    = i_win ? 2'b00 : (bus.d_sel == 2'b11 ? 2'b10 : bus.d_sel);
      mis_d    = ~i_win & (((bus.d_sel == 2'b00) & (|bus.d_addr[1:0])) |
                           ((bus.d_sel == 2'b01) & bus.d_addr[0]));
      starve_d = i_win ? '0 : ((bus.i_req & (starve_q != LIM)) ? starve_q + SW'(1) : starve_q);
    end
    i_ready_d = state_q == ACC_I;
    d_ready_d = state_q == ACC_D;
    d_err_d   = (state_q == ACC_D) & mis_q;
    i_rdata_d = state_q == ACC_I ? bus.mem_rdata : i_rdata_q;
    d_rdata_d = state_q == ACC_D ? bus.mem_rdata : d_rdata_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      sel_q     <= 2'b00;
      mis_q     <= 1'b0;
      starve_q  <= '0;
      i_ready_q <= 1'b0;
      d_ready_q <= 1'b0;
      d_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      mis_q     <= mis_d;
      starve_q  <= starve_d;
      i_ready_q <= i_ready_d;
      d_ready_q <= d_ready_d;
      d_err_q   <= d_err_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end
  // RAM side is driven only while an access is in flight; write is gated by reset
  assign bus.mem_addr  = (state_q == ACC_I || state_q == ACC_D) ? addr_q : '0;
  assign bus.mem_wdata = state_q == ACC_D ? wdata_q : '0;
  assign bus.mem_sel   = state_q == ACC_D ? sel_q : 2'b00;
  assign bus.mem_wen   = (state_q == ACC_D) & we_q & ~mis_q & ~RST;
  assign bus.i_ready   = i_ready_q;
  assign bus.i_rdata   = i_rdata_q;
  assign bus.d_ready   = d_ready_q;
  assign bus.d_rdata   = d_rdata_q;
  assign bus.d_err     = d_err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed stimulus with queued expectations checked by a ready-driven monitor
module tb_mem_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic init = 1'b1;
  always #5 clk = ~clk;
  mem_port_arbiter_if bus ();
  mem_port_arbiter dut (.CLK(clk), .RST(rst), .bus(bus));
  logic [7:0] ram [256];
  logic [7:0] ra;
  assign ra = bus.mem_addr[7:0];
  assign bus.mem_rdata = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
  always @(posedge clk) begin
    if (init) begin
      for (int k = 0; k < 256; k++) ram[k] <= 8'h00;
      ram[8'h10] <= 8'hEF;
      ram[8'h11] <= 8'hBE;
      ram[8'h12] <= 8'hAD;
      ram[8'h13] <= 8'hDE;
    end else if (bus.mem_wen) begin
      ram[ra] <= bus.mem_wdata[7:0];
      if (bus.mem_sel != 2'b10) ram[ra + 8'd1] <= bus.mem_wdata[15:8];
      if (bus.mem_sel == 2'b00) begin
        ram[ra + 8'd2] <= bus.mem_wdata[23:16];
        ram[ra + 8'd3] <= bus.mem_wdata[31:24];
      end
    end
  end
  function automatic logic [31:0] ramw(input logic [7:0] a);
    return {ram[a + 8'd3], ram[a + 8'd2], ram[a + 8'd1], ram[a]};
  endfunction
  typedef struct {logic [31:0] d; logic e;} dexp_t;
  dexp_t       dq [$];
  logic [31:0] iq [$];
  logic        gq [$];
  int          rcyc [$];
  int checks = 0, errors = 0, cyc = 0, rdy_cnt = 0, wen_cnt = 0;
  logic [1:0] last_sel = 2'b00;
  logic prev_i = 1'b0, prev_d = 1'b0;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  always @(posedge clk) cyc++;
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.mem_wen) begin
        wen_cnt++;
        last_sel = bus.mem_sel;
      end
      if (bus.i_ready || bus.d_ready) begin
        chk("ready_onehot", {31'd0, bus.i_ready & bus.d_ready}, 32'd0);
        gq.push_back(bus.i_ready);
        rcyc.push_back(cyc);
        rdy_cnt++;
      end
      if (bus.i_ready) begin
        chk("i_pulse", {31'd0, prev_i}, 32'd0);
        chk("i_queue", {31'd0, iq.size() != 0}, 32'd1);
        if (iq.size() != 0) chk("i_rdata", bus.i_rdata, iq.pop_front());
      end
      if (bus.d_ready) begin
        dexp_t e;
        chk("d_pulse", {31'd0, prev_d}, 32'd0);
        chk("d_queue", {31'd0, dq.size() != 0}, 32'd1);
        if (dq.size() != 0) begin
          e = dq.pop_front();
          chk("d_rdata", bus.d_rdata, e.d);
          chk("d_err", {31'd0, bus.d_err}, {31'd0, e.e});
        end
      end
      prev_i = bus.i_ready;
      prev_d = bus.d_ready;
    end
  end
  task automatic wait_rdy(input int n, input int budget);
    int s;
    int b;
    s = rdy_cnt;
    b = 0;
    while (rdy_cnt < s + n && b < budget) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk("ready_count", rdy_cnt - s, n);
  endtask
  task automatic d_access(input logic we, input logic [1:0] sel, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd, input logic exp_err);
    int t0;
    dexp_t e;
    e.d = exp_rd;
    e.e = exp_err;
    dq.push_back(e);
    @(posedge clk);
    #1;
    bus.d_we = we;
    bus.d_sel = sel;
    bus.d_addr = addr;
    bus.d_wdata = wdata;
    bus.d_req = 1'b1;
    t0 = cyc;
    wait_rdy(1, 10);
    bus.d_req = 1'b0;
    chk("d_latency", rcyc[$] - t0, 2);
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    int t0, w0, g0;
    logic [11:0] pat;
    bus.i_req = 1'b0;
    bus.i_addr = '0;
    bus.d_req = 1'b0;
    bus.d_we = 1'b0;
    bus.d_sel = 2'b00;
    bus.d_addr = '0;
    bus.d_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    init = 1'b0;
    chk("rst_i_ready", {31'd0, bus.i_ready}, 32'd0);
    chk("rst_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("rst_d_err", {31'd0, bus.d_err}, 32'd0);
    chk("rst_i_rdata", bus.i_rdata, 32'd0);
    chk("rst_d_rdata", bus.d_rdata, 32'd0);
    chk("rst_mem_wen", {31'd0, bus.mem_wen}, 32'd0);
    rst = 1'b0;
    // single fetch
    w0 = wen_cnt;
    iq.push_back(32'hDEADBEEF);
    @(posedge clk);
    #1;
    bus.i_addr = 32'h10;
    bus.i_req = 1'b1;
    t0 = cyc;
    wait_rdy(1, 10);
    bus.i_req = 1'b0;
    chk("i_latency", rcyc[$] - t0, 2);
    chk("fetch_no_write", wen_cnt, w0);
    // store then loads
    d_access(1'b1, 2'b00, 32'h40, 32'h11223344, 32'h0, 1'b0);
    chk("store_wen_once", wen_cnt, w0 + 1);
    d_access(1'b0, 2'b00, 32'h40, 32'h0, 32'h11223344, 1'b0);
    d_access(1'b0, 2'b10, 32'h41, 32'h0, 32'h00112233, 1'b0);
    chk("loads_no_write", wen_cnt, w0 + 1);
    // contention with starvation guard
    pat = 12'b0010_0001_0000;
    for (int k = 0; k < 12; k++) begin
      dexp_t e;
      e.d = 32'h11223344;
      e.e = 1'b0;
      if (pat[k]) iq.push_back(32'hDEADBEEF);
      else dq.push_back(e);
    end
    g0 = gq.size();
    @(posedge clk);
    #1;
    bus.i_addr = 32'h10;
    bus.d_we = 1'b0;
    bus.d_sel = 2'b00;
    bus.d_addr = 32'h40;
    bus.i_req = 1'b1;
    bus.d_req = 1'b1;
    wait_rdy(12, 60);
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;
    for (int k = 0; k < 12; k++) begin
      if (g0 + k < gq.size()) chk($sformatf("grant_%0d", k), {31'd0, gq[g0 + k]}, {31'd0, pat[k]});
      if (k > 0 && g0 + k < rcyc.size()) chk($sformatf("spacing_%0d", k), rcyc[g0 + k] - rcyc[g0 + k - 1], 3);
    end
    // misalignment
    w0 = wen_cnt;
    d_access(1'b1, 2'b00, 32'h42, 32'hFFFFFFFF, 32'h00001122, 1'b1);
    d_access(1'b1, 2'b01, 32'h43, 32'hFFFFFFFF, 32'h00000011, 1'b1);
    chk("misaligned_no_write", wen_cnt, w0);
    chk("ram_40_unchanged", ramw(8'h40), 32'h11223344);
    d_access(1'b1, 2'b01, 32'h42, 32'h0000BEEF, 32'h00001122, 1'b0);
    chk("half_write_once", wen_cnt, w0 + 1);
    chk("ram_40_half", ramw(8'h40), 32'hBEEF3344);
    // sel 11 behaves as byte
    d_access(1'b1, 2'b11, 32'h50, 32'hFFFFFFAB, 32'h0, 1'b0);
    chk("sel11_mem_sel", {30'd0, last_sel}, 32'd2);
    chk("ram_50_byte", ramw(8'h50), 32'h000000AB);
    chk("ram_4c_untouched", ramw(8'h4C), 32'h0);
    // reset in the ACC_D cycle of a store
    chk("starve_pre", 32'(dut.starve_q), 32'd2);
    w0 = wen_cnt;
    t0 = rdy_cnt;
    @(posedge clk);
    #1;
    bus.d_we = 1'b1;
    bus.d_sel = 2'b00;
    bus.d_addr = 32'h80;
    bus.d_wdata = 32'hCAFEBABE;
    bus.d_req = 1'b1;
    @(posedge clk);
    #1;
    chk("accd_wen_before_rst", {31'd0, bus.mem_wen}, 32'd1);
    rst = 1'b1;
    bus.d_req = 1'b0;
    #1;
    chk("rst_gates_wen", {31'd0, bus.mem_wen}, 32'd0);
    @(posedge clk);
    #1;
    chk("mid_rst_state", 32'(dut.state_q), 32'd0);
    chk("mid_rst_starve", 32'(dut.starve_q), 32'd0);
    chk("mid_rst_d_ready", {31'd0, bus.d_ready}, 32'd0);
    chk("mid_rst_i_ready", {31'd0, bus.i_ready}, 32'd0);
    chk("mid_rst_d_err", {31'd0, bus.d_err}, 32'd0);
    chk("ram_80_unchanged", ramw(8'h80), 32'h0);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("no_ready_after_rst", rdy_cnt, t0);
    chk("no_write_after_rst", wen_cnt, w0);
    chk("i_queue_drained", iq.size(), 0);
    chk("d_queue_drained", dq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
